// File: rtl/usb_pkg.sv
// Shared USB definitions: transmit FSM states, SYNC pattern, CRC16 constants
// and field lengths, used by both the transmit and receive paths.
package usb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_CRC,
        ST_EOP,
        ST_EOPJ
    } tx_state_t;

    // Sent LSB first: seven zeros followed by a one
    localparam logic [7:0]  SYNC_PATTERN   = 8'b1000_0000;

    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    localparam int unsigned SYNC_BITS  = 8;
    localparam int unsigned PID_BITS   = 8;
    localparam int unsigned CRC_BITS   = 16;
    localparam int unsigned EOP_CYCLES = 2;

endpackage

// File: rtl/crc16_gen.sv
// Serial CRC16 register (poly 16'h8005, init 16'hFFFF), MSB-first shift.
// Advances one bit per cycle while en is high and the stuffer is not stalling.
module crc16_gen
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        pause,
    input  logic        d,
    output logic [15:0] crc
);

    logic fb;

    always_comb begin
        fb = d ^ crc[15];
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            crc <= CRC16_INIT;
        end else if (en && !pause) begin
            crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/transmit_data.sv
// Serial USB packet transmitter: SYNC, PID, optional payload + CRC16, EOP.
// Optional feature macro: TRANSMIT_DATA_CRC_CORRUPT_EN adds crc_corrupt input.
module transmit_data
    import usb_pkg::*;
#(
    parameter int unsigned PAYLOAD_BITS = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [3:0]              pid,
    input  logic                    has_data,
    input  logic [PAYLOAD_BITS-1:0] data,
    input  logic                    pause,
`ifdef TRANSMIT_DATA_CRC_CORRUPT_EN
    input  logic                    crc_corrupt,
`endif
    output logic                    bit_out,
    output logic                    bit_valid,
    output logic                    stuff_en,
    output logic                    eop,
    output logic                    busy,
    output logic                    done
);

    tx_state_t               state, state_d;
    logic [6:0]              cnt;
    logic [7:0]              pid_byte;
    logic                    has_data_q;
    logic [PAYLOAD_BITS-1:0] data_sr;
    logic                    load;
    logic                    field_last;
    logic                    crc_en;
    logic [15:0]             crc;
    logic [3:0]              crc_idx;
`ifdef TRANSMIT_DATA_CRC_CORRUPT_EN
    logic                    corrupt_q;
`endif

    crc16_gen u_crc (
        .clk   (clk),
        .rst   (rst),
        .clr   (load),
        .en    (crc_en),
        .pause (pause),
        .d     (data_sr[0]),
        .crc   (crc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            pid_byte   <= '0;
            has_data_q <= 1'b0;
            data_sr    <= '0;
        end else begin
            state <= state_d;
            if (load) begin
                cnt        <= '0;
                pid_byte   <= {~pid, pid};
                has_data_q <= has_data;
                data_sr    <= data;
            end else if (!pause) begin
                if (field_last) begin
                    cnt <= '0;
                end else if (state != ST_IDLE) begin
                    cnt <= cnt + 7'd1;
                end
                if (state == ST_DATA) begin
                    data_sr <= data_sr >> 1;
                end
            end
        end
    end

`ifdef TRANSMIT_DATA_CRC_CORRUPT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            corrupt_q <= 1'b0;
        end else if (load) begin
            corrupt_q <= crc_corrupt;
        end
    end
`endif

    always_comb begin
        crc_idx = 4'd15 - cnt[3:0];
    end

    always_comb begin
        state_d    = state;
        load       = 1'b0;
        field_last = 1'b0;
        crc_en     = 1'b0;
        bit_out    = 1'b0;
        bit_valid  = 1'b0;
        stuff_en   = 1'b0;
        eop        = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                bit_out   = SYNC_PATTERN[cnt[2:0]];
                bit_valid = 1'b1;
                if (cnt == 7'(SYNC_BITS - 1)) begin
                    field_last = 1'b1;
                    state_d    = ST_PID;
                end
            end
            ST_PID: begin
                bit_out   = pid_byte[cnt[2:0]];
                bit_valid = 1'b1;
                stuff_en  = 1'b1;
                if (cnt == 7'(PID_BITS - 1)) begin
                    field_last = 1'b1;
                    state_d    = has_data_q ? ST_DATA : ST_EOP;
                end
            end
            ST_DATA: begin
                bit_out   = data_sr[0];
                bit_valid = 1'b1;
                stuff_en  = 1'b1;
                crc_en    = 1'b1;
                if (cnt == 7'(PAYLOAD_BITS - 1)) begin
                    field_last = 1'b1;
                    state_d    = ST_CRC;
                end
            end
            ST_CRC: begin
                bit_out   = ~crc[crc_idx];
`ifdef TRANSMIT_DATA_CRC_CORRUPT_EN
                if (corrupt_q && cnt == 7'(CRC_BITS - 1)) begin
                    bit_out = ~bit_out;
                end
`endif
                bit_valid = 1'b1;
                stuff_en  = 1'b1;
                if (cnt == 7'(CRC_BITS - 1)) begin
                    field_last = 1'b1;
                    state_d    = ST_EOP;
                end
            end
            ST_EOP: begin
                eop = 1'b1;
                if (cnt == 7'(EOP_CYCLES - 1)) begin
                    field_last = 1'b1;
                    state_d    = ST_EOPJ;
                end
            end
            ST_EOPJ: begin
                done       = 1'b1;
                field_last = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A stall freezes the FSM; the presented bit stays on bit_out unflagged
        if (pause && state != ST_IDLE) begin
            state_d    = state;
            field_last = 1'b0;
            bit_valid  = 1'b0;
            done       = 1'b0;
        end
    end

endmodule

// File: tb/tb_transmit_data.sv
// Directed self-checking bench for transmit_data: handshake, data packet,
// stalls, ignored starts, reset abort and (with the macro) CRC corruption.
module tb_transmit_data;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  pid;
    logic        has_data;
    logic [63:0] data;
    logic        pause;
    logic        bit_out, bit_valid, stuff_en, eop, busy, done;
`ifdef TRANSMIT_DATA_CRC_CORRUPT_EN
    logic        crc_corrupt = 1'b0;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic        rec_bits [0:255];
    logic        exp_bits [0:255];
    int unsigned n_valid, n_exp;
    int unsigned done_cyc, done_cnt, eop_first, eop_cnt;
    int unsigned hold_err, stuff_err, busy_err;
    logic [5:0]  rst_outs;

    transmit_data #(.PAYLOAD_BITS(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pid       (pid),
        .has_data  (has_data),
        .data      (data),
        .pause     (pause),
`ifdef TRANSMIT_DATA_CRC_CORRUPT_EN
        .crc_corrupt (crc_corrupt),
`endif
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .stuff_en  (stuff_en),
        .eop       (eop),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic b);
        logic fb;
        fb = b ^ c[15];
        return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    endfunction

    // Expected raw bitstream for a data packet
    task automatic build_exp(input logic [3:0] p, input logic [63:0] d, input logic corrupt);
        logic [7:0]  sync_v, pid_v;
        logic [15:0] c;
        sync_v = 8'b1000_0000;
        pid_v  = {~p, p};
        c      = 16'hFFFF;
        n_exp  = 0;
        for (int i = 0; i < 8; i++) begin exp_bits[n_exp] = sync_v[i]; n_exp++; end
        for (int i = 0; i < 8; i++) begin exp_bits[n_exp] = pid_v[i];  n_exp++; end
        for (int i = 0; i < 64; i++) begin
            exp_bits[n_exp] = d[i];
            n_exp++;
            c = ref_crc(c, d[i]);
        end
        for (int i = 15; i >= 0; i--) begin exp_bits[n_exp] = ~c[i]; n_exp++; end
        if (corrupt) exp_bits[n_exp-1] = ~exp_bits[n_exp-1];
    endtask

    function automatic int unsigned count_mism();
        int unsigned m;
        m = 0;
        for (int unsigned i = 0; i < n_exp; i++)
            if (rec_bits[i] !== exp_bits[i]) m++;
        return m;
    endfunction

    function automatic logic [15:0] residual();
        logic [15:0] c;
        c = 16'hFFFF;
        for (int unsigned i = 16; i < n_valid; i++) c = ref_crc(c, rec_bits[i]);
        return c;
    endfunction

    // Cycle 1 is the first cycle after the edge that samples start
    task automatic run_pkt(input logic [3:0] p, input logic hd, input logic [63:0] d,
                           input int unsigned ps, input int unsigned pl, input int unsigned pe,
                           input int unsigned s1, input int unsigned s2, input int unsigned rc,
                           input int unsigned ncyc);
        logic prev_bit, prev_pause;
        n_valid = 0; done_cyc = 0; done_cnt = 0; eop_first = 0; eop_cnt = 0;
        hold_err = 0; stuff_err = 0; busy_err = 0; rst_outs = '1;
        prev_bit = 1'b0; prev_pause = 1'b0;
        pid = p; has_data = hd; data = d;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int unsigned c = 1; c <= ncyc; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            pause = (c >= ps && c < ps + pl) || (c == pe);
            start = (c == s1) || (c == s2);
            rst   = (c == rc);
            @(negedge clk);
            if (bit_valid) begin
                rec_bits[n_valid] = bit_out;
                if (stuff_en !== (n_valid >= 8)) stuff_err++;
                n_valid++;
            end
            if (pause && busy) begin
                if (bit_valid !== 1'b0) hold_err++;
                if (prev_pause && bit_out !== prev_bit) hold_err++;
            end
            prev_bit   = bit_out;
            prev_pause = pause;
            if (eop) begin
                if (eop_cnt == 0) eop_first = c;
                eop_cnt++;
            end
            if (done) begin
                if (done_cnt == 0) done_cyc = c;
                done_cnt++;
            end
            if (rc != 0 && c == rc + 1)
                rst_outs = {bit_out, bit_valid, stuff_en, eop, busy, done};
            if (rc == 0 && busy !== (done_cnt == 0 || c == done_cyc)) busy_err++;
        end
        start = 1'b0; pause = 1'b0; rst = 1'b0;
    endtask

    localparam logic [63:0] PAYLOAD = 64'h0123_4567_89AB_CDEF;

    initial begin
        logic [15:0] hs;
        rst = 1'b1; start = 1'b0; pid = '0; has_data = 1'b0; data = '0; pause = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", 32'({bit_out, bit_valid, stuff_en, eop, busy, done}), 32'h0);
        #1 rst = 1'b0;

        // Handshake ACK
        run_pkt(4'h2, 1'b0, 64'h0, 0, 0, 0, 0, 0, 0, 25);
        hs = 16'b0000_0001_0100_1011;
        n_exp = 16;
        for (int i = 0; i < 16; i++) exp_bits[i] = hs[15-i];
        chk("hs_nbits", n_valid, 16);
        chk("hs_bits", count_mism(), 0);
        chk("hs_eop_first", eop_first, 17);
        chk("hs_eop_len", eop_cnt, 2);
        chk("hs_done_cyc", done_cyc, 19);
        chk("hs_done_cnt", done_cnt, 1);
        chk("hs_busy", busy_err, 0);
        chk("hs_stuff_en", stuff_err, 0);

        // Data packet, no stall
        build_exp(4'h3, PAYLOAD, 1'b0);
        run_pkt(4'h3, 1'b1, PAYLOAD, 0, 0, 0, 0, 0, 0, 110);
        chk("dp_nbits", n_valid, 96);
        chk("dp_bits", count_mism(), 0);
        chk("dp_residual", residual(), 32'h800D);
        chk("dp_eop_first", eop_first, 97);
        chk("dp_done_cyc", done_cyc, 99);
        chk("dp_busy", busy_err, 0);
        chk("dp_stuff_en", stuff_err, 0);

        // Stall 3 cycles at bit 20 and 1 cycle at the first EOP cycle
        run_pkt(4'h3, 1'b1, PAYLOAD, 21, 3, 100, 0, 0, 0, 110);
        chk("ps_nbits", n_valid, 96);
        chk("ps_bits", count_mism(), 0);
        chk("ps_hold", hold_err, 0);
        chk("ps_eop_first", eop_first, 100);
        chk("ps_done_cyc", done_cyc, 103);
        chk("ps_done_cnt", done_cnt, 1);

        // start mid-DATA and in the done cycle are both ignored
        run_pkt(4'h3, 1'b1, PAYLOAD, 0, 0, 0, 40, 99, 0, 105);
        chk("sb_bits", count_mism(), 0);
        chk("sb_done_cyc", done_cyc, 99);
        chk("sb_busy_after", busy_err, 0);

        // Reset at CRC bit 5 (cycle 86)
        run_pkt(4'h3, 1'b1, PAYLOAD, 0, 0, 0, 0, 0, 86, 100);
        chk("rs_outs", 32'(rst_outs), 32'h0);
        chk("rs_no_done", done_cnt, 0);
        chk("rs_no_eop", eop_cnt, 0);

        // Clean packet after the abort
        run_pkt(4'h3, 1'b1, PAYLOAD, 0, 0, 0, 0, 0, 0, 110);
        chk("rc_bits", count_mism(), 0);
        chk("rc_done_cyc", done_cyc, 99);

`ifdef TRANSMIT_DATA_CRC_CORRUPT_EN
        crc_corrupt = 1'b1;
        build_exp(4'h3, PAYLOAD, 1'b1);
        run_pkt(4'h3, 1'b1, PAYLOAD, 0, 0, 0, 0, 0, 0, 110);
        crc_corrupt = 1'b0;
        chk("cc_bits", count_mism(), 0);
        chk("cc_residual_bad", 32'(residual() != 16'h800D), 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
